// File: rtl/dm_store_if.sv
// Bus bundle between the M-stage pipeline logic and the dm_store data memory.
interface dm_store_if;
  logic [31:0] PC;
  logic [31:0] addr;
  logic [31:0] WD;
  logic        MemWrite;
  logic [1:0]  storeOP;
  logic [31:0] DM_W;
  logic        store_err;

  modport master (
    output PC, addr, WD, MemWrite, storeOP,
    input  DM_W, store_err
  );

  modport slave (
    input  PC, addr, WD, MemWrite, storeOP,
    output DM_W, store_err
  );
endinterface

// File: rtl/dm_store.sv
// M-stage data memory: word-addressed RAM with sw/sb/sh merge and a raw-word read port.
// Optional write logging is compiled in with DM_DISPLAY_EN.
module dm_store #(
  parameter int unsigned ADDR_W = 12
) (
  input logic       clk,
  input logic       reset,
  dm_store_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              out_of_range;
  logic [31:0]       cur;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       merged;
  logic              bad;
  logic              suppressed;
  logic              commit;
  logic              err_q;

  assign idx          = bus.addr[ADDR_W+1:2];
  assign out_of_range = |bus.addr[31:ADDR_W+2];
  assign cur          = mem[idx];

  assign bus.DM_W      = out_of_range ? '0 : cur;
  assign bus.store_err = err_q;

  // Store data is replicated across lanes so each enabled lane picks its own copy.
  always_comb begin
    be    = '0;
    bad   = 1'b0;
    wdata = bus.WD;
    case (bus.storeOP)
      2'b00: begin
        be  = '1;
        bad = |bus.addr[1:0];
      end
      2'b01: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.WD[7:0]}};
      end
      2'b10: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.WD[15:0]}};
        bad   = bus.addr[0];
      end
      default: bad = 1'b1;
    endcase
    bad = bad | out_of_range;
  end

  always_comb begin
    merged = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  assign suppressed = bus.MemWrite & bad;
  assign commit     = bus.MemWrite & ~bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
      err_q <= 1'b0;
    end else begin
      if (commit) mem[idx] <= merged;
      err_q <= suppressed;
    end
  end

`ifdef DM_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset && commit)
      $display("%0t@%h: *%h <= %h", $time, bus.PC, {bus.addr[31:2], 2'b00}, merged);
  end
`else
  logic pc_unused;
  assign pc_unused = ^bus.PC;
`endif

endmodule

// File: tb/tb_dm_store.sv
// Directed self-checking bench for dm_store: store merging, suppression, read-during-write, reset.
module tb_dm_store;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dm_store_if bus ();

  dm_store #(.ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    bus.MemWrite = we;
    bus.storeOP  = op;
    bus.addr     = a;
    bus.WD       = d;
    bus.PC       = 32'h0040_0000 + a;
  endtask

  // One store cycle, then idle with addr left on the target word so DM_W reads it back.
  task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, op, a, d);
    tick();
    drive(1'b0, 2'b00, a, 32'h0);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 2'b00, 32'h10, 32'h0);
    #3;
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL reset_dm_w: got %h expected %h", bus.DM_W, 32'h0);
    end
    checks++;
    if (bus.store_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_store_err: got %b expected %b", bus.store_err, 1'b0);
    end
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_word_store();
    store(2'b00, 32'h10, 32'h1234_5678);
    checks++;
    if (bus.DM_W !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sw_0x10: got %h expected %h", bus.DM_W, 32'h1234_5678);
    end
    checks++;
    if (bus.store_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_store_err: got %b expected %b", bus.store_err, 1'b0);
    end
  endtask

  task automatic test_byte_store();
    store(2'b01, 32'h11, 32'hFFFF_FFAB);
    checks++;
    if (bus.DM_W !== 32'h1234_AB78) begin
      errors++;
      $display("FAIL sb_0x11: got %h expected %h", bus.DM_W, 32'h1234_AB78);
    end
    store(2'b01, 32'h13, 32'h0000_00CD);
    checks++;
    if (bus.DM_W !== 32'hCD34_AB78) begin
      errors++;
      $display("FAIL sb_0x13: got %h expected %h", bus.DM_W, 32'hCD34_AB78);
    end
  endtask

  task automatic test_half_store();
    store(2'b10, 32'h12, 32'h0000_BEEF);
    checks++;
    if (bus.DM_W !== 32'hBEEF_AB78) begin
      errors++;
      $display("FAIL sh_0x12: got %h expected %h", bus.DM_W, 32'hBEEF_AB78);
    end
    store(2'b10, 32'h10, 32'h9999_0102);
    checks++;
    if (bus.DM_W !== 32'hBEEF_0102) begin
      errors++;
      $display("FAIL sh_0x10: got %h expected %h", bus.DM_W, 32'hBEEF_0102);
    end
  endtask

  task automatic test_suppressed();
    store(2'b00, 32'h20, 32'h1111_2222);
    store(2'b10, 32'h21, 32'hFFFF_FFFF);
    checks++;
    if (bus.store_err !== 1'b1) begin
      errors++;
      $display("FAIL sh_misaligned_err: got %b expected %b", bus.store_err, 1'b1);
    end
    checks++;
    if (bus.DM_W !== 32'h1111_2222) begin
      errors++;
      $display("FAIL sh_misaligned_mem: got %h expected %h", bus.DM_W, 32'h1111_2222);
    end
    tick();
    checks++;
    if (bus.store_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clears: got %b expected %b", bus.store_err, 1'b0);
    end

    store(2'b00, 32'h22, 32'h3333_4444);
    checks++;
    if (bus.store_err !== 1'b1) begin
      errors++;
      $display("FAIL sw_misaligned_err: got %b expected %b", bus.store_err, 1'b1);
    end
    checks++;
    if (bus.DM_W !== 32'h1111_2222) begin
      errors++;
      $display("FAIL sw_misaligned_mem: got %h expected %h", bus.DM_W, 32'h1111_2222);
    end

    store(2'b11, 32'h20, 32'h5555_6666);
    checks++;
    if (bus.store_err !== 1'b1) begin
      errors++;
      $display("FAIL reserved_op_err: got %b expected %b", bus.store_err, 1'b1);
    end
    checks++;
    if (bus.DM_W !== 32'h1111_2222) begin
      errors++;
      $display("FAIL reserved_op_mem: got %h expected %h", bus.DM_W, 32'h1111_2222);
    end

    store(2'b00, 32'h0001_0000, 32'hCAFE_F00D);
    checks++;
    if (bus.store_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_err: got %b expected %b", bus.store_err, 1'b1);
    end
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: got %h expected %h", bus.DM_W, 32'h0);
    end
    // 0x0001_0000 aliases word 0 in the index bits; word 0 must stay untouched.
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL oor_alias_word0: got %h expected %h", bus.DM_W, 32'h0);
    end

    drive(1'b0, 2'b11, 32'h21, 32'h0);
    tick();
    checks++;
    if (bus.store_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_op: got %b expected %b", bus.store_err, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 32'h30, 32'hAAAA_AAAA);
    #1;
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL rdw_cycle1: got %h expected %h", bus.DM_W, 32'h0);
    end
    tick();
    drive(1'b1, 2'b01, 32'h30, 32'h0000_0055);
    #1;
    checks++;
    if (bus.DM_W !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL rdw_cycle2: got %h expected %h", bus.DM_W, 32'hAAAA_AAAA);
    end
    tick();
    drive(1'b0, 2'b00, 32'h30, 32'h0);
    #1;
    checks++;
    if (bus.DM_W !== 32'hAAAA_AA55) begin
      errors++;
      $display("FAIL rdw_cycle3: got %h expected %h", bus.DM_W, 32'hAAAA_AA55);
    end
  endtask

  task automatic test_reset_mid_run();
    // Leave store_err set so the asynchronous clear is observable.
    store(2'b10, 32'h41, 32'h0000_1234);
    drive(1'b1, 2'b00, 32'h40, 32'hDEAD_BEEF);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.store_err !== 1'b0) begin
      errors++;
      $display("FAIL async_err_clear: got %b expected %b", bus.store_err, 1'b0);
    end
    bus.addr = 32'h10;
    #1;
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL async_clear_0x10: got %h expected %h", bus.DM_W, 32'h0);
    end
    bus.addr = 32'h30;
    #1;
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL async_clear_0x30: got %h expected %h", bus.DM_W, 32'h0);
    end
    bus.addr = 32'h40;
    tick();
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL no_write_in_reset: got %h expected %h", bus.DM_W, 32'h0);
    end
    drive(1'b0, 2'b00, 32'h40, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.DM_W !== 32'h0) begin
      errors++;
      $display("FAIL store_dropped_0x40: got %h expected %h", bus.DM_W, 32'h0);
    end
    store(2'b00, 32'h40, 32'h0BAD_F00D);
    checks++;
    if (bus.DM_W !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL post_reset_sw: got %h expected %h", bus.DM_W, 32'h0BAD_F00D);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_half_store();
    test_suppressed();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
